perf_readout_sequencer: RTL

PERF_READOUT_SEQUENCER -- requirements
Module: perf_readout_sequencer

---
 rtl/perf_readout_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/perf_readout_sequencer.sv
// Sequences one performance-monitor measurement: clear the counters, wait for the window
// to close, then read each stream counter out as one AXI-Stream beat.
module perf_readout_sequencer #(
  parameter int          NUM_STREAMS    = 2,
  parameter int          SETTLE_CYCLES  = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0010_0000
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] command,
  input  logic        ready_to_read,
  input  logic [31:0] counter_value,
  output logic        M_AXIS_TVALID,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_SELECT,
    S_CAPTURE,
    S_SEND,
    S_FINISH
  } state_t;

  localparam logic [4:0]  LAST_INDEX  = 5'(NUM_STREAMS - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST   = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] CLEAR_WORD  = 32'h0000_0040;

  state_t      state;
  logic [4:0]  index;
  logic [31:0] wait_count;
  logic [3:0]  settle_count;
  logic        clear_count;

  function automatic logic [31:0] address_word(input logic [4:0] addr);
    return {26'd0, addr, 1'b0};
  endfunction

  // The read address is driven from SELECT onwards and only changes on a handshake,
  // so the monitor output has settled by the time CAPTURE samples it.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      command       <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      index         <= '0;
      wait_count    <= '0;
      settle_count  <= '0;
      clear_count   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_CLEAR;
            busy        <= 1'b1;
            timeout     <= 1'b0;
            index       <= '0;
            clear_count <= 1'b0;
            command     <= CLEAR_WORD;
          end
        end
        S_CLEAR: begin
          if (clear_count) begin
            state      <= S_WAIT;
            command    <= '0;
            wait_count <= '0;
          end else begin
            clear_count <= 1'b1;
          end
        end
        S_WAIT: begin
          // ready_to_read is tested first so it wins over a simultaneous timeout
          if (ready_to_read) begin
            state        <= S_SELECT;
            command      <= address_word(index);
            settle_count <= '0;
          end else if (wait_count == WAIT_LAST) begin
            state   <= S_FINISH;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else begin
            wait_count <= wait_count + 32'd1;
          end
        end
        S_SELECT: begin
          if (settle_count == SETTLE_LAST) begin
            state <= S_CAPTURE;
          end else begin
            settle_count <= settle_count + 4'd1;
          end
        end
        S_CAPTURE: begin
          state         <= S_SEND;
          M_AXIS_TVALID <= 1'b1;
          M_AXIS_TDATA  <= {27'd0, index, counter_value};
          M_AXIS_TLAST  <= (index == LAST_INDEX);
        end
        S_SEND: begin
          if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
            if (index == LAST_INDEX) begin
              state   <= S_FINISH;
              command <= '0;
              done    <= 1'b1;
            end else begin
              state        <= S_SELECT;
              index        <= index + 5'd1;
              command      <= address_word(index + 5'd1);
              settle_count <= '0;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
